// File: rtl/fpu_csr_pkg.sv
// Shared constants for the FP CSR slice: CSR addresses, access opcodes,
// RISC-V and adder rounding-mode encodings, and fflags bit positions.
package fpu_csr_pkg;

  localparam logic [11:0] CSR_ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_ADDR_FRM    = 12'h002;
  localparam logic [11:0] CSR_ADDR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam logic [1:0] FADD_RNE = 2'b00;
  localparam logic [1:0] FADD_RDN = 2'b01;
  localparam logic [1:0] FADD_RUP = 2'b10;
  localparam logic [1:0] FADD_RTZ = 2'b11;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Result of a CSR write/set/clear on an 8-bit field image; read leaves it intact.
  function automatic logic [7:0] csr_apply(input csr_op_e op, input logic [7:0] old_v,
                                           input logic [7:0] data);
    case (op)
      CSR_OP_WRITE: csr_apply = data;
      CSR_OP_SET:   csr_apply = old_v | data;
      CSR_OP_CLEAR: csr_apply = old_v & ~data;
      default:      csr_apply = old_v;
    endcase
  endfunction

endpackage

// File: rtl/fpu_rm_decode.sv
// Combinational rounding-mode resolution: picks static or dynamic rm and maps
// it onto the adder's 2-bit encoding, flagging modes the adder cannot do.
module fpu_rm_decode
  import fpu_csr_pkg::*;
(
  input  logic [2:0] instr_rm,
  input  logic [2:0] frm,
  output logic [1:0] fadd_rm,
  output logic       rm_illegal
);

  logic [2:0] eff_rm;

  always_comb begin
    eff_rm     = (instr_rm == RM_DYN) ? frm : instr_rm;
    fadd_rm    = FADD_RNE;
    rm_illegal = 1'b0;
    case (eff_rm)
      RM_RNE:  fadd_rm = FADD_RNE;
      RM_RTZ:  fadd_rm = FADD_RTZ;
      RM_RDN:  fadd_rm = FADD_RDN;
      RM_RUP:  fadd_rm = FADD_RUP;
      // RMM, reserved codes, and a dynamic frm that is itself DYN
      default: rm_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_csr.sv
// fflags/frm/fcsr register block for the FP adder: accumulates adder exception
// flags through a one-entry pending stage and serves single-cycle CSR accesses.
module fpu_csr
  import fpu_csr_pkg::*;
#(
  parameter logic [2:0]  RESET_FRM   = 3'b000,
  parameter logic [11:0] ADDR_FFLAGS = CSR_ADDR_FFLAGS,
  parameter logic [11:0] ADDR_FRM    = CSR_ADDR_FRM,
  parameter logic [11:0] ADDR_FCSR   = CSR_ADDR_FCSR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fp_valid,
  input  logic        fp_invalid,
  input  logic        fp_of,
  input  logic        fp_uf,
  input  logic        fp_nx,
  input  logic [2:0]  instr_rm,
  output logic [1:0]  fadd_rm,
  output logic        rm_illegal,
  input  logic        csr_req,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        csr_rvalid,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [2:0]  frm,
  output logic [4:0]  fflags
);

  // CSR handshake: csr_req is a one-cycle strobe with no backpressure, so a new
  // access may arrive every cycle; csr_rvalid answers each one exactly one cycle later.

  logic [4:0]  pend_flags;
  logic        pend_valid;
  logic [4:0]  in_flags;
  logic [4:0]  pend_merge;
  logic        sel_ff, sel_frm, sel_fcsr, addr_hit, wr_en;
  logic [7:0]  old_img, new_img;
  logic [31:0] rd_val;
  logic [4:0]  fflags_nxt;
  logic [2:0]  frm_nxt;
  csr_op_e     op;

  fpu_rm_decode u_rm_decode (
    .instr_rm   (instr_rm),
    .frm        (frm),
    .fadd_rm    (fadd_rm),
    .rm_illegal (rm_illegal)
  );

  always_comb begin
    in_flags          = '0;
    in_flags[FLAG_NV] = fp_invalid;
    in_flags[FLAG_OF] = fp_of;
    in_flags[FLAG_UF] = fp_uf;
    in_flags[FLAG_NX] = fp_nx;
  end

  always_comb begin
    op         = csr_op_e'(csr_op);
    pend_merge = pend_valid ? pend_flags : 5'b0;
    sel_ff     = (csr_addr == ADDR_FFLAGS);
    sel_frm    = (csr_addr == ADDR_FRM);
    sel_fcsr   = (csr_addr == ADDR_FCSR);
    addr_hit   = sel_ff | sel_frm | sel_fcsr;
    wr_en      = csr_req && addr_hit && (op != CSR_OP_READ);

    // Read returns the pre-write value, with flags still in the pending stage folded in.
    rd_val = 32'b0;
    if (sel_ff)   rd_val = {27'b0, fflags | pend_merge};
    if (sel_frm)  rd_val = {29'b0, frm};
    if (sel_fcsr) rd_val = {24'b0, frm, fflags | pend_merge};

    old_img = 8'b0;
    if (sel_ff)   old_img = {3'b0, fflags};
    if (sel_frm)  old_img = {5'b0, frm};
    if (sel_fcsr) old_img = {frm, fflags};
    new_img = csr_apply(op, old_img, csr_wdata[7:0]);

    fflags_nxt = fflags;
    frm_nxt    = frm;
    if (wr_en) begin
      if (sel_ff)   fflags_nxt = new_img[4:0];
      if (sel_frm)  frm_nxt    = new_img[2:0];
      if (sel_fcsr) {frm_nxt, fflags_nxt} = new_img;
    end
    // Pending adder flags survive a same-cycle CSR write to fflags.
    fflags_nxt = fflags_nxt | pend_merge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags      <= 5'b0;
      frm         <= RESET_FRM;
      pend_valid  <= 1'b0;
      pend_flags  <= 5'b0;
      csr_rvalid  <= 1'b0;
      csr_rdata   <= 32'b0;
      csr_illegal <= 1'b0;
    end else begin
      fflags      <= fflags_nxt;
      frm         <= frm_nxt;
      pend_valid  <= fp_valid;
      pend_flags  <= fp_valid ? in_flags : 5'b0;
      csr_rvalid  <= csr_req;
      csr_rdata   <= (csr_req && addr_hit) ? rd_val : 32'b0;
      csr_illegal <= csr_req && !addr_hit;
    end
  end

endmodule

// File: tb/tb_fpu_csr.sv
// Directed bench for fpu_csr: each task drives one scenario and checks
// outputs against hand-computed values, sampling on the falling clock edge.
module tb_fpu_csr;

  logic        clk;
  logic        rst_n;
  logic        fp_valid, fp_invalid, fp_of, fp_uf, fp_nx;
  logic [2:0]  instr_rm;
  logic [1:0]  fadd_rm;
  logic        rm_illegal;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [2:0]  frm;
  logic [4:0]  fflags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  fpu_csr dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fp_valid    (fp_valid),
    .fp_invalid  (fp_invalid),
    .fp_of       (fp_of),
    .fp_uf       (fp_uf),
    .fp_nx       (fp_nx),
    .instr_rm    (instr_rm),
    .fadd_rm     (fadd_rm),
    .rm_illegal  (rm_illegal),
    .csr_req     (csr_req),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rvalid  (csr_rvalid),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .frm         (frm),
    .fflags      (fflags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic csr_issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_req   = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
  endtask

  task automatic csr_idle();
    csr_req   = 1'b0;
    csr_op    = 2'b00;
    csr_addr  = 12'h0;
    csr_wdata = 32'h0;
  endtask

  // One access; returns at the falling edge where the response is visible.
  task automatic csr_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    @(negedge clk);
    csr_issue(op, addr, wd);
    @(negedge clk);
    csr_idle();
  endtask

  task automatic set_flags(input logic v, input logic nv, input logic of_, input logic uf, input logic nx);
    fp_valid = v; fp_invalid = nv; fp_of = of_; fp_uf = uf; fp_nx = nx;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_flags(0, 0, 0, 0, 0);
    instr_rm = 3'b000;
    csr_idle();
    apply_reset();
    n_checks++; if (fflags !== 5'b0) begin n_fail++; $display("FAIL reset_fflags got %b exp 00000", fflags); end
    n_checks++; if (frm !== 3'b000) begin n_fail++; $display("FAIL reset_frm got %b exp 000", frm); end
    n_checks++; if (csr_rvalid !== 1'b0 || csr_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b/%b exp 0/0", csr_rvalid, csr_illegal); end
    n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", csr_rdata); end
    csr_access(2'b00, 12'h003, 32'h0);
    n_checks++; if (csr_rvalid !== 1'b1) begin n_fail++; $display("FAIL fcsr_read_rvalid got %b exp 1", csr_rvalid); end
    n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL fcsr_read_rdata got %h exp 0", csr_rdata); end
    @(negedge clk);
    n_checks++; if (csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got %b exp 0", csr_rvalid); end
  endtask

  task automatic test_rounding();
    csr_access(2'b01, 12'h002, 32'h0000_0003);
    n_checks++; if (frm !== 3'b011) begin n_fail++; $display("FAIL frm_write got %b exp 011", frm); end
    instr_rm = 3'b111; #1;
    n_checks++; if (fadd_rm !== 2'b10 || rm_illegal !== 1'b0) begin n_fail++; $display("FAIL rm_dyn got %b/%b exp 10/0", fadd_rm, rm_illegal); end
    instr_rm = 3'b101; #1;
    n_checks++; if (fadd_rm !== 2'b00 || rm_illegal !== 1'b1) begin n_fail++; $display("FAIL rm_101 got %b/%b exp 00/1", fadd_rm, rm_illegal); end
    instr_rm = 3'b001; #1;
    n_checks++; if (fadd_rm !== 2'b11 || rm_illegal !== 1'b0) begin n_fail++; $display("FAIL rm_rtz got %b/%b exp 11/0", fadd_rm, rm_illegal); end
    instr_rm = 3'b010; #1;
    n_checks++; if (fadd_rm !== 2'b01 || rm_illegal !== 1'b0) begin n_fail++; $display("FAIL rm_rdn got %b/%b exp 01/0", fadd_rm, rm_illegal); end
    instr_rm = 3'b000; #1;
    n_checks++; if (fadd_rm !== 2'b00 || rm_illegal !== 1'b0) begin n_fail++; $display("FAIL rm_rne got %b/%b exp 00/0", fadd_rm, rm_illegal); end
    csr_access(2'b01, 12'h002, 32'hFFFF_FFF6);
    instr_rm = 3'b111; #1;
    n_checks++; if (frm !== 3'b110 || rm_illegal !== 1'b1 || fadd_rm !== 2'b00) begin n_fail++; $display("FAIL rm_dyn_110 got frm=%b %b/%b exp 110 00/1", frm, fadd_rm, rm_illegal); end
    instr_rm = 3'b000;
    csr_access(2'b01, 12'h002, 32'h0000_0003);
    n_checks++; if (csr_rdata !== 32'h6) begin n_fail++; $display("FAIL frm_old_read got %h exp 6", csr_rdata); end
  endtask

  task automatic test_flag_accum();
    @(negedge clk);
    set_flags(1, 0, 1, 0, 1);
    @(negedge clk);
    set_flags(0, 0, 0, 0, 0);
    csr_issue(2'b00, 12'h001, 32'h0);
    @(negedge clk);
    csr_idle();
    n_checks++; if (fflags !== 5'b00101) begin n_fail++; $display("FAIL flag_merge got %b exp 00101", fflags); end
    n_checks++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h5) begin n_fail++; $display("FAIL flag_bypass_read got %b/%h exp 1/5", csr_rvalid, csr_rdata); end
    set_flags(0, 1, 1, 1, 1);
    repeat (3) @(negedge clk);
    set_flags(0, 0, 0, 0, 0);
    n_checks++; if (fflags !== 5'b00101) begin n_fail++; $display("FAIL flags_without_valid got %b exp 00101", fflags); end
  endtask

  task automatic test_clear_merge();
    @(negedge clk);
    set_flags(1, 1, 0, 0, 0);
    @(negedge clk);
    set_flags(0, 0, 0, 0, 0);
    csr_issue(2'b11, 12'h001, 32'h0000_0001);
    @(negedge clk);
    csr_idle();
    n_checks++; if (fflags !== 5'b10100) begin n_fail++; $display("FAIL clear_merge got %b exp 10100", fflags); end
    n_checks++; if (csr_rdata !== 32'h15) begin n_fail++; $display("FAIL clear_merge_old got %h exp 15", csr_rdata); end
  endtask

  task automatic test_ops();
    csr_access(2'b10, 12'h001, 32'h0000_0002);
    n_checks++; if (fflags !== 5'b10110 || csr_rdata !== 32'h14) begin n_fail++; $display("FAIL set_op got %b/%h exp 10110/14", fflags, csr_rdata); end
    csr_access(2'b00, 12'h003, 32'hFFFF_FFFF);
    n_checks++; if (csr_rdata !== 32'h76 || fflags !== 5'b10110 || frm !== 3'b011) begin n_fail++; $display("FAIL read_only got %h %b %b exp 76 10110 011", csr_rdata, fflags, frm); end
    csr_access(2'b01, 12'h003, 32'hFFFF_FF2A);
    n_checks++; if (csr_rdata !== 32'h76 || fflags !== 5'b01010 || frm !== 3'b001) begin n_fail++; $display("FAIL fcsr_write got %h %b %b exp 76 01010 001", csr_rdata, fflags, frm); end
  endtask

  task automatic test_illegal();
    csr_access(2'b01, 12'h7C0, 32'h0000_00FF);
    n_checks++; if (csr_illegal !== 1'b1 || csr_rvalid !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got %b/%b exp 1/1", csr_illegal, csr_rvalid); end
    n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL illegal_rdata got %h exp 0", csr_rdata); end
    n_checks++; if (fflags !== 5'b01010 || frm !== 3'b001) begin n_fail++; $display("FAIL illegal_state got %b %b exp 01010 001", fflags, frm); end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h0A);
    @(negedge clk);
    csr_issue(2'b01, 12'h002, 32'h0000_0004);
    @(negedge clk);
    csr_issue(2'b00, 12'h002, 32'h0);
    n_checks++; exp_v = exp_q.pop_front();
    if (csr_rvalid !== 1'b1 || csr_rdata !== exp_v) begin n_fail++; $display("FAIL b2b_0 got %b/%h exp 1/%h", csr_rvalid, csr_rdata, exp_v); end
    @(negedge clk);
    csr_issue(2'b11, 12'h001, 32'h0000_001F);
    n_checks++; exp_v = exp_q.pop_front();
    if (csr_rvalid !== 1'b1 || csr_rdata !== exp_v) begin n_fail++; $display("FAIL b2b_1 got %b/%h exp 1/%h", csr_rvalid, csr_rdata, exp_v); end
    @(negedge clk);
    csr_idle();
    n_checks++; exp_v = exp_q.pop_front();
    if (csr_rvalid !== 1'b1 || csr_rdata !== exp_v) begin n_fail++; $display("FAIL b2b_2 got %b/%h exp 1/%h", csr_rvalid, csr_rdata, exp_v); end
    n_checks++; if (fflags !== 5'b0 || frm !== 3'b100) begin n_fail++; $display("FAIL b2b_state got %b %b exp 00000 100", fflags, frm); end
    instr_rm = 3'b111; #1;
    n_checks++; if (rm_illegal !== 1'b1 || fadd_rm !== 2'b00) begin n_fail++; $display("FAIL rm_dyn_rmm got %b/%b exp 1/00", rm_illegal, fadd_rm); end
    instr_rm = 3'b000;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    set_flags(1, 1, 1, 1, 1);
    @(negedge clk);
    set_flags(0, 0, 0, 0, 0);
    csr_issue(2'b01, 12'h003, 32'h0000_00FF);
    rst_n = 1'b0;
    #1;
    n_checks++; if (fflags !== 5'b0 || frm !== 3'b000) begin n_fail++; $display("FAIL async_reset got %b %b exp 00000 000", fflags, frm); end
    @(negedge clk);
    csr_idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (fflags !== 5'b0) begin n_fail++; $display("FAIL no_late_merge got %b exp 00000", fflags); end
    n_checks++; if (frm !== 3'b000 || csr_rvalid !== 1'b0 || csr_rdata !== 32'h0) begin n_fail++; $display("FAIL post_reset got %b %b %h exp 000 0 0", frm, csr_rvalid, csr_rdata); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_rounding();
    test_flag_accum();
    test_clear_merge();
    test_ops();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_csr.md
FPU_CSR -- requirements
Module: fpu_csr

Interface
REQ-001 Parameter: RESET_FRM, 3'b000, value loaded into frm at reset.
REQ-002 Parameter: ADDR_FFLAGS / ADDR_FRM / ADDR_FCSR, 12'h001 / 12'h002 / 12'h003, decoded CSR addresses.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 fp_valid  input  1  adder result retiring this cycle; its flags are to be accumulated.
REQ-007 fp_invalid, fp_of, fp_uf, fp_nx  input  1 each  adder exception flags (Invalid, OF, UF, NX).
REQ-008 instr_rm  input  3  RISC-V rm field of the issuing FP instruction.
REQ-009 fadd_rm  output  2  adder round mode: 00 RNE, 01 toward -inf, 10 toward +inf, 11 toward zero.
REQ-010 rm_illegal  output  1  resolved rounding mode is unsupported.
REQ-011 csr_req  input  1  CSR access strobe, one cycle per access.
REQ-012 csr_op  input  2  01 write, 10 set bits, 11 clear bits, 00 read-only.
REQ-013 csr_addr  input  12  CSR address.
REQ-014 csr_wdata  input  32  CSR write/mask data.
REQ-015 csr_rvalid  output  1  read data valid, one cycle after csr_req.
REQ-016 csr_rdata  output  32  old CSR value, zero-extended.
REQ-017 csr_illegal  output  1  address miss, asserted alongside csr_rvalid.
REQ-018 frm  output  3  current dynamic rounding mode.
REQ-019 fflags  output  5  current flags {NV,DZ,OF,UF,NX}.

Function
REQ-020 fflags SHALL map NV=fp_invalid, DZ=0, OF=fp_of, UF=fp_uf, NX=fp_nx.
REQ-021 Rounding-mode resolution SHALL be combinational; effective = frm when instr_rm==3'b111, else instr_rm.
REQ-022 Mapping SHALL be 000->00, 001->11, 010->01, 011->10.
REQ-023 Effective modes 100 through 110 SHALL assert rm_illegal and drive fadd_rm=00.
REQ-024 Incoming flags SHALL be registered in a one-entry stage (pend_flags, pend_valid) and ORed into fflags one cycle after fp_valid.
REQ-025 A CSR access SHALL be registered; csr_rvalid SHALL pulse exactly one cycle after csr_req.
REQ-026 csr_rdata SHALL hold the value before the write, with pend_flags bypassed in when pend_valid is set that cycle.
REQ-027 Read layout: fflags -> {27'b0,fflags}, frm -> {29'b0,frm}, fcsr -> {24'b0,frm,fflags}.
REQ-028 Writes SHALL apply at the same edge as the read capture; only low 5/3/8 bits are used.
REQ-029 When a CSR write and a pend_flags merge hit fflags in the same cycle, the new fflags SHALL equal the written value OR pend_flags.
REQ-030 Unknown csr_addr SHALL assert csr_illegal with csr_rdata=0 and leave no state change.
REQ-031 csr_op=00 SHALL not modify state.
REQ-032 A back-to-back csr_req SHALL be accepted every cycle.
REQ-033 fp_valid=0 SHALL leave pending flags ignored, whatever the flag inputs are.

Reset
REQ-034 On rst_n low the block SHALL asynchronously set fflags=0, frm=RESET_FRM, pend_valid=0, pend_flags=0, csr_rvalid=0, csr_rdata=0, csr_illegal=0.
REQ-035 A reset asserted mid-access or with flags pending SHALL discard them, with no late merge after release.

Structure
REQ-036 A shared package SHALL hold the CSR address constants, the csr_op encodings, the RISC-V rm encodings, the adder rm encodings and the fflags bit indices.
REQ-037 Rounding-mode resolution SHALL be a sub-module fpu_rm_decode (instr_rm, frm -> fadd_rm, rm_illegal), purely combinational.

Verification
REQ-038 Reset, then read 0x003 -> csr_rvalid one cycle later, csr_rdata=32'h0.
REQ-039 Write 0x002 data 3'b011, then set instr_rm=111 -> frm=011, fadd_rm=10; instr_rm=101 -> rm_illegal=1, fadd_rm=00.
REQ-040 fp_valid with fp_of=1, fp_nx=1 -> fflags=5'b00101 two edges later; a read of 0x001 issued the next cycle also returns 5.
REQ-041 Clear op on 0x001 mask 5'b00001 in the same cycle pend_flags=5'b10000 merges -> fflags=5'b10100.
REQ-042 Access to 0x7C0 -> csr_illegal=1, csr_rdata=0, fflags/frm unchanged.
REQ-043 Assert rst_n low one cycle after fp_valid -> fflags=0 after release, no late merge.
